// File: rtl/snd_cmd_mailbox.sv
// Host-to-sound-Z80 command mailbox: NUM_CH byte FIFOs popped through Z80 IO ports,
// with INT (IM0 vector merged with the YM2151 IRQ) and NMI raised from per-channel non-empty status.
module snd_cmd_mailbox #(
  parameter int                NUM_CH     = 2,
  parameter int                DEPTH_LOG2 = 2,
  parameter logic [7:0]        IO_BASE    = 8'h02,
  parameter logic [NUM_CH-1:0] NMI_MASK   = 2'b10,
  parameter logic [NUM_CH-1:0] POP_ON_RD  = 2'b10,
  localparam int               CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              pause,
  input  logic              host_wr,
  input  logic [CHW-1:0]    host_ch,
  input  logic [7:0]        host_data,
  output logic [NUM_CH-1:0] host_full,
  output logic [NUM_CH-1:0] ovf,
  input  logic [7:0]        z80_addr,
  input  logic [7:0]        z80_dout,
  input  logic              z80_iorq_n,
  input  logic              z80_rd_n,
  input  logic              z80_wr_n,
  input  logic              z80_m1_n,
  input  logic              ext_irq_n,
  output logic [7:0]        z80_din,
  output logic              z80_din_vld,
  output logic              int_n,
  output logic              nmi_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = (DEPTH_LOG2 > 0) ? DEPTH_LOG2 : 1;
  localparam int MEMD  = 1 << PW;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] PTR_MASK = PW'(DEPTH - 1);

  // A depth-1 build still uses a 1-bit pointer; the mask pins it to slot 0.
  logic [7:0]        mem_q      [NUM_CH][MEMD];
  logic [7:0]        mem_d      [NUM_CH][MEMD];
  logic [PW-1:0]     wr_ptr_q   [NUM_CH];
  logic [PW-1:0]     wr_ptr_d   [NUM_CH];
  logic [PW-1:0]     rd_ptr_q   [NUM_CH];
  logic [PW-1:0]     rd_ptr_d   [NUM_CH];
  logic [CW-1:0]     count_q    [NUM_CH];
  logic [CW-1:0]     count_d    [NUM_CH];
  logic [7:0]        last_pop_q [NUM_CH];
  logic [7:0]        last_pop_d [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic              iorq_old_q, iorq_old_d;
  logic              int_n_q, int_n_d;
  logic              nmi_n_q, nmi_n_d;

  logic [NUM_CH-1:0] nonempty;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] data_hit;
  logic [NUM_CH-1:0] stat_hit;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop_req;
  logic [NUM_CH-1:0] clr_ovf;
  logic              io_fall;
  logic              int_pend;
  logic              dout_unused;

  // Write data content is irrelevant; only the write strobe matters for decode.
  assign dout_unused = ^z80_dout;

  // One pop/clear event per IO access: the IORQ falling edge, outside INTA, frozen by pause.
  assign io_fall = iorq_old_q & ~z80_iorq_n & z80_m1_n & ~pause;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      nonempty[c] = (count_q[c] != '0);
      full[c]     = (count_q[c] == CW'(DEPTH));
      data_hit[c] = (z80_addr == 8'(IO_BASE + 8'(2 * c)));
      stat_hit[c] = (z80_addr == 8'(IO_BASE + 8'(2 * c + 1)));
      push[c]     = host_wr & (host_ch == CHW'(c));
      pop_req[c]  = io_fall & (POP_ON_RD[c] ? (~z80_rd_n & data_hit[c])
                                            : (~z80_wr_n & stat_hit[c]));
      clr_ovf[c]  = io_fall & ~z80_rd_n & stat_hit[c];
    end
  end

  assign int_pend = |(nonempty & ~NMI_MASK);

  always_comb begin
    logic do_pop;
    logic push_ok;
    logic overwrite;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_pop_d = last_pop_q;
    ovf_d      = ovf_q;
    do_pop     = 1'b0;
    push_ok    = 1'b0;
    overwrite  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      do_pop    = pop_req[c] & nonempty[c];
      // A pop in the same cycle frees the head slot, so a push into a full FIFO is a normal push.
      push_ok   = push[c] & (~full[c] | do_pop);
      overwrite = push[c] & full[c] & ~do_pop;
      if (do_pop) begin
        last_pop_d[c] = mem_q[c][rd_ptr_q[c]];
        rd_ptr_d[c]   = (rd_ptr_q[c] + PW'(1)) & PTR_MASK;
      end
      if (push_ok) begin
        mem_d[c][wr_ptr_q[c]] = host_data;
        wr_ptr_d[c]           = (wr_ptr_q[c] + PW'(1)) & PTR_MASK;
      end else if (overwrite) begin
        mem_d[c][(wr_ptr_q[c] - PW'(1)) & PTR_MASK] = host_data;
      end
      if (push_ok && !do_pop) begin
        count_d[c] = count_q[c] + CW'(1);
      end else if (do_pop && !push_ok) begin
        count_d[c] = count_q[c] - CW'(1);
      end
      if (clr_ovf[c]) begin
        ovf_d[c] = 1'b0;
      end
      if (overwrite) begin
        ovf_d[c] = 1'b1;
      end
    end
    iorq_old_d = pause ? iorq_old_q : z80_iorq_n;
    int_n_d    = ~(int_pend | ~ext_irq_n);
    nmi_n_d    = ~|(nonempty & NMI_MASK);
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c]   <= '0;
        rd_ptr_q[c]   <= '0;
        count_q[c]    <= '0;
        last_pop_q[c] <= 8'hFF;
      end
      ovf_q      <= '0;
      iorq_old_q <= 1'b1;
      int_n_q    <= 1'b1;
      nmi_n_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_pop_q <= last_pop_d;
      ovf_q      <= ovf_d;
      iorq_old_q <= iorq_old_d;
      int_n_q    <= int_n_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its entries.
  always_ff @(posedge CLK_32M) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    z80_din     = 8'hFF;
    z80_din_vld = 1'b0;
    if (!z80_m1_n && !z80_iorq_n) begin
      z80_din     = {2'b11, ~int_pend, ext_irq_n, 4'b1111};
      z80_din_vld = 1'b1;
    end else if (!z80_iorq_n && !z80_rd_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (data_hit[c]) begin
          z80_din     = nonempty[c] ? mem_q[c][rd_ptr_q[c]] : last_pop_q[c];
          z80_din_vld = 1'b1;
        end else if (stat_hit[c]) begin
          z80_din     = {ovf_q[c], full[c], ~nonempty[c], 5'(count_q[c])};
          z80_din_vld = 1'b1;
        end
      end
    end
  end

  assign host_full = full;
  assign ovf       = ovf_q;
  assign int_n     = int_n_q;
  assign nmi_n     = nmi_n_q;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench for snd_cmd_mailbox: default build plus a DEPTH_LOG2=0 build sharing the Z80 bus.
module tb_snd_cmd_mailbox;

  logic       CLK_32M = 1'b0;
  logic       reset;
  logic       pause;
  logic       host_wr, host_wr0;
  logic [0:0] host_ch, host_ch0;
  logic [7:0] host_data, host_data0;
  logic [1:0] host_full, host_full0;
  logic [1:0] ovf, ovf0;
  logic [7:0] z80_addr, z80_dout;
  logic       z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n, ext_irq_n;
  logic [7:0] z80_din, z80_din0;
  logic       z80_din_vld, z80_din_vld0;
  logic       int_n, int_n0, nmi_n, nmi_n0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK_32M = ~CLK_32M;

  snd_cmd_mailbox dut (
    .CLK_32M(CLK_32M), .reset(reset), .pause(pause),
    .host_wr(host_wr), .host_ch(host_ch), .host_data(host_data),
    .host_full(host_full), .ovf(ovf),
    .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_iorq_n(z80_iorq_n),
    .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n),
    .ext_irq_n(ext_irq_n), .z80_din(z80_din), .z80_din_vld(z80_din_vld),
    .int_n(int_n), .nmi_n(nmi_n)
  );

  snd_cmd_mailbox #(.DEPTH_LOG2(0)) dut_d0 (
    .CLK_32M(CLK_32M), .reset(reset), .pause(pause),
    .host_wr(host_wr0), .host_ch(host_ch0), .host_data(host_data0),
    .host_full(host_full0), .ovf(ovf0),
    .z80_addr(z80_addr), .z80_dout(z80_dout), .z80_iorq_n(z80_iorq_n),
    .z80_rd_n(z80_rd_n), .z80_wr_n(z80_wr_n), .z80_m1_n(z80_m1_n),
    .ext_irq_n(ext_irq_n), .z80_din(z80_din0), .z80_din_vld(z80_din_vld0),
    .int_n(int_n0), .nmi_n(nmi_n0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [0:0] ch, input logic [7:0] data);
    @(posedge CLK_32M); #1;
    host_wr = 1'b1; host_ch = ch; host_data = data;
    @(posedge CLK_32M); #1;
    host_wr = 1'b0;
  endtask

  task automatic push0(input logic [0:0] ch, input logic [7:0] data);
    @(posedge CLK_32M); #1;
    host_wr0 = 1'b1; host_ch0 = ch; host_data0 = data;
    @(posedge CLK_32M); #1;
    host_wr0 = 1'b0;
  endtask

  // IORQ held low for two edges: the pop lands on the first, the second proves no double pop.
  task automatic z80_io(input logic [7:0] addr, input bit rd,
                        output logic [7:0] d, output logic v, output logic [7:0] d0);
    @(posedge CLK_32M); #1;
    z80_addr = addr; z80_iorq_n = 1'b0;
    if (rd) z80_rd_n = 1'b0; else z80_wr_n = 1'b0;
    @(negedge CLK_32M);
    d = z80_din; v = z80_din_vld; d0 = z80_din0;
    @(posedge CLK_32M); #1;
    @(posedge CLK_32M); #1;
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_addr = 8'h00;
  endtask

  task automatic inta(output logic [7:0] d, output logic v);
    @(posedge CLK_32M); #1;
    z80_m1_n = 1'b0; z80_iorq_n = 1'b0;
    @(negedge CLK_32M);
    d = z80_din; v = z80_din_vld;
    @(posedge CLK_32M); #1;
    z80_m1_n = 1'b1; z80_iorq_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d, d0;
    logic       v;
    logic [7:0] exp_b;
    reset = 1'b1; pause = 1'b0;
    host_wr = 1'b0; host_ch = 1'b0; host_data = 8'h00;
    host_wr0 = 1'b0; host_ch0 = 1'b0; host_data0 = 8'h00;
    z80_addr = 8'h00; z80_dout = 8'h5A; z80_iorq_n = 1'b1;
    z80_rd_n = 1'b1; z80_wr_n = 1'b1; z80_m1_n = 1'b1; ext_irq_n = 1'b1;
    repeat (3) @(posedge CLK_32M);
    #1 reset = 1'b0;

    // Reset state
    @(negedge CLK_32M);
    check_eq("rst_int_n", int_n, 1);
    check_eq("rst_nmi_n", nmi_n, 1);
    check_eq("rst_full", host_full, 2'b00);
    check_eq("rst_ovf", ovf, 2'b00);
    check_eq("rst_din_idle", z80_din, 8'hFF);
    check_eq("rst_vld_idle", z80_din_vld, 0);
    z80_io(8'h02, 1, d, v, d0);
    check_eq("rst_last_pop", d, 8'hFF);
    check_eq("rst_data_vld", v, 1);
    z80_io(8'h03, 1, d, v, d0);
    check_eq("rst_status", d, 8'h20);

    // Push to ch0 raises INT one cycle after the count changes
    push(1'b0, 8'h12);
    check_eq("t1_int_latency", int_n, 1);
    @(posedge CLK_32M); #1;
    check_eq("t1_int_n", int_n, 0);
    check_eq("t1_nmi_n", nmi_n, 1);
    inta(d, v);
    check_eq("t1_vector", d, 8'hDF);
    check_eq("t1_vector_vld", v, 1);
    z80_io(8'h02, 1, d, v, d0);
    check_eq("t1_data", d, 8'h12);
    z80_io(8'h03, 1, d, v, d0);
    check_eq("t1_no_pop_status", d, 8'h01);

    // Status-port write pops ch0
    z80_io(8'h03, 0, d, v, d0);
    check_eq("t2_int_n", int_n, 1);
    z80_io(8'h03, 1, d, v, d0);
    check_eq("t2_status", d, 8'h20);
    z80_io(8'h02, 1, d, v, d0);
    check_eq("t2_last_pop", d, 8'h12);

    // Fill ch1 past capacity
    for (int i = 0; i < 4; i++) push(1'b1, 8'hA1 + 8'(i));
    check_eq("t3_full4", host_full, 2'b10);
    check_eq("t3_ovf_before", ovf, 2'b00);
    push(1'b1, 8'hA5);
    check_eq("t3_ovf", ovf, 2'b10);
    check_eq("t3_full5", host_full, 2'b10);
    @(posedge CLK_32M); #1;
    check_eq("t3_nmi_n", nmi_n, 0);
    check_eq("t3_int_n", int_n, 1);
    z80_io(8'h05, 1, d, v, d0);
    check_eq("t3_status", d, 8'hC4);
    check_eq("t3_ovf_cleared", ovf, 2'b00);

    // Simultaneous push and pop on a full ch1
    @(posedge CLK_32M); #1;
    host_wr = 1'b1; host_ch = 1'b1; host_data = 8'hB6;
    z80_addr = 8'h04; z80_iorq_n = 1'b0; z80_rd_n = 1'b0;
    @(negedge CLK_32M);
    d = z80_din;
    @(posedge CLK_32M); #1;
    host_wr = 1'b0;
    @(posedge CLK_32M); #1;
    z80_iorq_n = 1'b1; z80_rd_n = 1'b1; z80_addr = 8'h00;
    check_eq("t4_popped", d, 8'hA1);
    check_eq("t4_ovf", ovf, 2'b00);
    z80_io(8'h05, 1, d, v, d0);
    check_eq("t4_status", d, 8'h44);

    // Drain ch1: A2, A3, A5 (A4 was overwritten), B6
    z80_io(8'h04, 1, d, v, d0); check_eq("t3_rd1", d, 8'hA2);
    z80_io(8'h04, 1, d, v, d0); check_eq("t3_rd2", d, 8'hA3);
    z80_io(8'h04, 1, d, v, d0); check_eq("t3_rd3", d, 8'hA5);
    check_eq("t3_nmi_held", nmi_n, 0);
    z80_io(8'h04, 1, d, v, d0); check_eq("t3_rd4", d, 8'hB6);
    check_eq("t3_nmi_release", nmi_n, 1);
    z80_io(8'h04, 1, d, v, d0); check_eq("t3_empty_last", d, 8'hB6);
    z80_io(8'h05, 1, d, v, d0); check_eq("t3_empty_status", d, 8'h20);

    // Pause blocks pops but not host pushes
    @(posedge CLK_32M); #1 pause = 1'b1;
    push(1'b1, 8'h55);
    z80_io(8'h04, 1, d, v, d0);
    check_eq("t5_paused_data", d, 8'h55);
    @(posedge CLK_32M); #1 pause = 1'b0;
    z80_io(8'h05, 1, d, v, d0);
    check_eq("t5_no_pop", d, 8'h01);
    z80_io(8'h04, 1, d, v, d0);
    check_eq("t5_pop_data", d, 8'h55);
    z80_io(8'h05, 1, d, v, d0);
    check_eq("t5_popped", d, 8'h20);

    // External YM2151 IRQ with FIFOs empty
    @(posedge CLK_32M); #1 ext_irq_n = 1'b0;
    @(posedge CLK_32M); #1;
    check_eq("t6_int_n_ext", int_n, 0);
    inta(d, v);
    check_eq("t6_vector", d, 8'hEF);
    ext_irq_n = 1'b1;
    @(posedge CLK_32M); #1;
    check_eq("t6_int_n_release", int_n, 1);

    // Reset mid-transfer drops the stored entry and a coincident push
    push(1'b0, 8'h77);
    @(posedge CLK_32M); #1;
    reset = 1'b1; host_wr = 1'b1; host_ch = 1'b0; host_data = 8'h88;
    @(posedge CLK_32M); #1;
    reset = 1'b0; host_wr = 1'b0;
    @(negedge CLK_32M);
    check_eq("rst2_int_n", int_n, 1);
    z80_io(8'h03, 1, d, v, d0);
    check_eq("rst2_status", d, 8'h20);
    z80_io(8'h02, 1, d, v, d0);
    check_eq("rst2_last_pop", d, 8'hFF);

    // Single-latch build: second push overwrites
    push0(1'b0, 8'h31);
    check_eq("d0_full", host_full0, 2'b01);
    check_eq("d0_ovf_before", ovf0, 2'b00);
    push0(1'b0, 8'h32);
    check_eq("d0_ovf", ovf0, 2'b01);
    z80_io(8'h02, 1, d, v, d0);
    check_eq("d0_data", d0, 8'h32);
    z80_io(8'h03, 1, d, v, d0);
    exp_b = 8'hC1;
    check_eq("d0_status", d0, exp_b);
    z80_io(8'h03, 0, d, v, d0);
    z80_io(8'h03, 1, d, v, d0);
    check_eq("d0_status_after", d0, 8'h20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
